// File: rtl/game_sprite_pkg.sv
// Shared widths, screen geometry and signed position/velocity types for the
// sprite motion engine.
package game_sprite_pkg;
  localparam int POS_W    = 11;
  localparam int D_W      = 4;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [D_W-1:0]   vel_t;

  function automatic pos_t sext_vel(input vel_t v);
    return {{(POS_W-D_W){v[D_W-1]}}, v};
  endfunction
endpackage

// File: rtl/game_sprite_step_timer.sv
// Divides qualifying frame strobes by STEP_DIV; step pulses on the strobe that
// wraps the count, so the position update lands on the same edge.
module game_sprite_step_timer #(
  parameter int STEP_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic en,
  input  logic clr,
  output logic step
);
  localparam int            CW   = $clog2(STEP_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          adv;

  assign adv  = strobe & en & ~clr;
  assign step = adv && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || step) cnt_d = '0;
    else if (adv)    cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/game_sprite_motion.sv
// Per-sprite position/velocity engine: latches commands, steps on divided frame
// strobes, flags on-screen state and produces a registered raster hit/offset.
module game_sprite_motion
  import game_sprite_pkg::*;
#(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int STEP_DIV = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        write_xy,
  input  logic                        write_dxy,
  input  logic                        enable_update,
  input  logic                        frame_strobe,
  input  logic [POS_W-1:0]            x0,
  input  logic [POS_W-1:0]            y0,
  input  logic [D_W-1:0]              dx0,
  input  logic [D_W-1:0]              dy0,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  output logic [POS_W-1:0]            x,
  output logic [POS_W-1:0]            y,
  output logic                        within_screen,
  output logic                        pixel_hit,
  output logic [$clog2(SPRITE_W)-1:0] pixel_col,
  output logic [$clog2(SPRITE_H)-1:0] pixel_row
);
  localparam int CXW = $clog2(SPRITE_W);
  localparam int CYW = $clog2(SPRITE_H);
  localparam int XW  = POS_W + 1;
  typedef logic signed [XW-1:0] wide_t;

  localparam pos_t  X_MIN = pos_t'(-SPRITE_W);
  localparam pos_t  Y_MIN = pos_t'(-SPRITE_H);
  localparam pos_t  X_MAX = pos_t'(SCREEN_W);
  localparam pos_t  Y_MAX = pos_t'(SCREEN_H);
  localparam wide_t SW_W  = wide_t'(SPRITE_W);
  localparam wide_t SH_W  = wide_t'(SPRITE_H);

  pos_t           x_q, x_d, y_q, y_d;
  vel_t           dx_q, dy_q;
  logic           ws_q, ws_d, hit_q, hit_d;
  logic [CXW-1:0] col_q, col_d;
  logic [CYW-1:0] row_q, row_d;
  wide_t          dpx, dpy;
  logic           step;

  game_sprite_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .strobe (frame_strobe),
    .en     (enable_update),
    .clr    (write_xy),
    .step   (step)
  );

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (write_xy) begin
      x_d = x0;
      y_d = y0;
    end else if (step) begin
      x_d = x_q + sext_vel(dx_q);
      y_d = y_q + sext_vel(dy_q);
    end
    // Computed from next-state so the flag tracks the position it describes.
    ws_d = (x_d > X_MIN) && (x_d < X_MAX) && (y_d > Y_MIN) && (y_d < Y_MAX);

    dpx   = wide_t'({2'b00, pixel_x}) - {x_q[POS_W-1], x_q};
    dpy   = wide_t'({2'b00, pixel_y}) - {y_q[POS_W-1], y_q};
    hit_d = !dpx[XW-1] && (dpx < SW_W) && !dpy[XW-1] && (dpy < SH_W);
    col_d = hit_d ? dpx[CXW-1:0] : '0;
    row_d = hit_d ? dpy[CYW-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '0;
      y_q   <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      ws_q  <= 1'b1;
      hit_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      ws_q  <= ws_d;
      hit_q <= hit_d;
      col_q <= col_d;
      row_q <= row_d;
      if (write_dxy) begin
        dx_q <= dx0;
        dy_q <= dy0;
      end
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign within_screen = ws_q;
  assign pixel_hit     = hit_q;
  assign pixel_col     = col_q;
  assign pixel_row     = row_q;
endmodule

// File: tb/tb_game_sprite_motion.sv
// Scoreboard bench for game_sprite_motion with STEP_DIV=2 and 8x8 sprites.
module tb_game_sprite_motion;
  localparam int STEP_DIV = 2;
  localparam int SPR      = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               write_xy = 1'b0, write_dxy = 1'b0;
  logic               enable_update = 1'b0, frame_strobe = 1'b0;
  logic signed [10:0] x0 = '0, y0 = '0;
  logic signed [3:0]  dx0 = '0, dy0 = '0;
  logic [9:0]         pixel_x = '1, pixel_y = '1;
  logic signed [10:0] x, y;
  logic               within_screen, pixel_hit;
  logic [2:0]         pixel_col, pixel_row;

  game_sprite_motion #(.SPRITE_W(SPR), .SPRITE_H(SPR), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .rst(rst), .write_xy(write_xy), .write_dxy(write_dxy),
    .enable_update(enable_update), .frame_strobe(frame_strobe),
    .x0(x0), .y0(y0), .dx0(dx0), .dy0(dy0),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .x(x), .y(y), .within_screen(within_screen),
    .pixel_hit(pixel_hit), .pixel_col(pixel_col), .pixel_row(pixel_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [10:0] x, y;
    logic               ws, hit;
    logic [2:0]         col, row;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   mx = 0, my = 0, mdx = 0, mdy = 0, mcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model predicts the post-edge outputs.
  task automatic drive(input logic wxy, input logic wdxy, input logic en, input logic fs,
                       input int nx0, input int ny0, input int ndx, input int ndy,
                       input int px, input int py);
    exp_t e;
    logic stp;
    int   dpx, dpy, nx, ny;
    write_xy = wxy; write_dxy = wdxy; enable_update = en; frame_strobe = fs;
    x0 = 11'(nx0); y0 = 11'(ny0); dx0 = 4'(ndx); dy0 = 4'(ndy);
    pixel_x = 10'(px); pixel_y = 10'(py);

    stp   = fs && en && !wxy && (mcnt == STEP_DIV - 1);
    dpx   = px - mx;
    dpy   = py - my;
    e.hit = (dpx >= 0) && (dpx < SPR) && (dpy >= 0) && (dpy < SPR);
    e.col = e.hit ? 3'(dpx) : 3'd0;
    e.row = e.hit ? 3'(dpy) : 3'd0;
    nx = wxy ? nx0 : (stp ? mx + mdx : mx);
    ny = wxy ? ny0 : (stp ? my + mdy : my);
    e.x  = 11'(nx);
    e.y  = 11'(ny);
    e.ws = (nx > -SPR) && (nx < 640) && (ny > -SPR) && (ny < 480);
    if (wxy)            mcnt = 0;
    else if (fs && en)  mcnt = (mcnt == STEP_DIV - 1) ? 0 : mcnt + 1;
    if (wdxy) begin mdx = ndx; mdy = ndy; end
    mx = nx; my = ny;
    sb.push_back(e);

    @(posedge clk); #1;
    e = sb.pop_front();
    chk("x",   x,             e.x);
    chk("y",   y,             e.y);
    chk("ws",  within_screen, e.ws);
    chk("hit", pixel_hit,     e.hit);
    chk("col", pixel_col,     e.col);
    chk("row", pixel_row,     e.row);
  endtask

  task automatic st();
    drive(0, 0, 1, 1, 0, 0, 0, 0, 1023, 1023);
  endtask

  task automatic load(input int ax, input int ay, input int adx, input int ady);
    drive(1, 1, 0, 0, ax, ay, adx, ady, 1023, 1023);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_ws", within_screen, 1);
    chk("rst_hit", pixel_hit, 0);

    // Strobes while disabled: nothing moves.
    repeat (5) drive(0, 0, 0, 1, 0, 0, 0, 0, 1023, 1023);
    chk("hold_x", x, 0);

    // Basic motion: changes only on the 2nd and 4th strobe.
    load(100, 200, 3, -2);
    st(); chk("s1_x", x, 100);
    st(); chk("s2_x", x, 103); chk("s2_y", y, 198);
    st(); chk("s3_x", x, 103);
    st(); chk("s4_x", x, 106); chk("s4_y", y, 196);

    // Right edge.
    load(635, 100, 2, 0);
    st(); st(); chk("r637_x", x, 637); chk("r637_ws", within_screen, 1);
    st(); st(); chk("r639_ws", within_screen, 1);
    st(); st(); chk("r641_x", x, 641); chk("r641_ws", within_screen, 0);

    // Left edge.
    load(-6, 100, -1, 0);
    st(); st(); chk("l7_x", x, -7); chk("l7_ws", within_screen, 1);
    st(); st(); chk("l8_x", x, -8); chk("l8_ws", within_screen, 0);

    // write_xy beats a step-firing strobe and clears the counter.
    load(20, 20, 1, 1);
    st();
    drive(1, 0, 1, 1, 50, 30, 0, 0, 1023, 1023);
    chk("wxy_x", x, 50);
    st(); chk("wxy_nostep", x, 50);
    st(); chk("wxy_step", x, 51);

    // write_dxy alongside a step: old velocity used first.
    st();
    drive(0, 1, 1, 1, 0, 0, 4, 4, 1023, 1023);
    chk("wdxy_old", x, 52);
    st(); st(); chk("wdxy_new", x, 56);

    // Pixel path.
    load(10, 20, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 17, 27);
    chk("px_hit", pixel_hit, 1); chk("px_col", pixel_col, 7); chk("px_row", pixel_row, 7);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 18, 27);
    chk("px_miss", pixel_hit, 0); chk("px_miss_col", pixel_col, 0);
    load(-3, -2, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pp_hit", pixel_hit, 1); chk("pp_col", pixel_col, 3); chk("pp_row", pixel_row, 2);

    // Asynchronous reset mid-move.
    load(300, 100, 2, 0);
    st();
    #3 rst = 1'b0;
    #1;
    chk("arst_x", x, 0);
    chk("arst_ws", within_screen, 1);
    mx = 0; my = 0; mdx = 0; mdy = 0; mcnt = 0;
    @(posedge clk); #1 rst = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 5, 0, 1023, 1023);
    st(); chk("post_rst_nostep", x, 0);
    st(); chk("post_rst_step", x, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
